tone_sample_writer: RTL and testbench



---
 rtl/tone_sample_writer.sv | 157 +++++++++++++++
 tb/tb_tone_sample_writer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sample_writer.sv
// Turns a tone player's square wave into enveloped signed PCM samples and
// pushes them into the codec FIFO through its allowed/write handshake.
module tone_sample_writer #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int SAMPLE_RATE = 48000,
    parameter int SAMPLE_BITS = 24,
    parameter logic [SAMPLE_BITS-1:0] AMPLITUDE = 'h100000,
    parameter logic [SAMPLE_BITS-1:0] RAMP_STEP = 'h001000,
    parameter int HOLD_SAMPLES = 1024
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          sound,
    input  logic                          audio_out_allowed,
    output logic                          write_audio_out,
    output logic signed [SAMPLE_BITS-1:0] left_channel_audio_out,
    output logic signed [SAMPLE_BITS-1:0] right_channel_audio_out,
    output logic                          overrun
);

    localparam int DIVISOR = CLOCK_FREQUENCY / SAMPLE_RATE;
    localparam int DIV_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int ACT_W = $clog2(HOLD_SAMPLES) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);
    localparam logic [ACT_W-1:0] HOLD_LOAD = ACT_W'(HOLD_SAMPLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TICK,
        WRITE
    } state_t;

    state_t                 stateReg, stateNext;
    logic [DIV_W-1:0]       dividerReg, dividerNext;
    logic [SAMPLE_BITS-1:0] levelReg, levelNext;
    logic [ACT_W-1:0]       activityReg, activityNext;
    logic [SAMPLE_BITS-1:0] sampleReg, sampleNext;
    logic                   overrunReg, overrunNext;
    logic [2:0]             syncChain;
    logic                   writeStrobe;

    logic                   syncSound;
    logic                   soundEdge;
    logic                   tick;
    logic                   active;
    logic [SAMPLE_BITS:0]   levelSum;
    logic [SAMPLE_BITS-1:0] rampUp;
    logic [SAMPLE_BITS-1:0] rampDown;
    logic [SAMPLE_BITS-1:0] levelTick;
    logic [SAMPLE_BITS-1:0] sampleValue;

    // syncChain[1] is the synchronized sound, syncChain[2] its previous value.
    assign syncSound = syncChain[1];
    assign soundEdge = syncChain[1] ^ syncChain[2];
    assign tick      = (stateReg != IDLE) && (dividerReg == DIV_LAST);
    assign active    = (activityReg != '0);

    // One extra bit keeps the ramp-up sum from wrapping near full scale.
    assign levelSum    = {1'b0, levelReg} + {1'b0, RAMP_STEP};
    assign rampUp      = (levelSum > {1'b0, AMPLITUDE}) ? AMPLITUDE : levelSum[SAMPLE_BITS-1:0];
    assign rampDown    = (levelReg < RAMP_STEP) ? '0 : (levelReg - RAMP_STEP);
    assign levelTick   = active ? rampUp : rampDown;
    assign sampleValue = syncSound ? levelTick : (~levelTick + 1'b1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateReg    <= IDLE;
            dividerReg  <= '0;
            levelReg    <= '0;
            activityReg <= '0;
            sampleReg   <= '0;
            overrunReg  <= 1'b0;
            syncChain   <= '0;
        end else begin
            stateReg    <= stateNext;
            dividerReg  <= dividerNext;
            levelReg    <= levelNext;
            activityReg <= activityNext;
            sampleReg   <= sampleNext;
            overrunReg  <= overrunNext;
            syncChain   <= {syncChain[1:0], sound};
        end
    end

    always_comb begin
        stateNext    = stateReg;
        dividerNext  = dividerReg;
        levelNext    = levelReg;
        activityNext = activityReg;
        sampleNext   = sampleReg;
        overrunNext  = overrunReg;
        writeStrobe  = 1'b0;

        if (stateReg != IDLE) begin
            dividerNext = tick ? '0 : (dividerReg + 1'b1);
            if (soundEdge) begin
                activityNext = HOLD_LOAD;
            end else if (tick && active) begin
                activityNext = activityReg - 1'b1;
            end
            if (tick) begin
                levelNext = levelTick;
            end
        end

        case (stateReg)
            IDLE: begin
                dividerNext  = '0;
                levelNext    = '0;
                activityNext = '0;
                sampleNext   = '0;
                overrunNext  = 1'b0;
                if (enable) begin
                    stateNext = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (tick) begin
                    sampleNext = sampleValue;
                    stateNext  = WRITE;
                end
            end
            WRITE: begin
                writeStrobe = audio_out_allowed;
                if (tick) begin
                    // Old sample leaves this cycle if allowed; otherwise it is lost.
                    sampleNext = sampleValue;
                    if (!audio_out_allowed) begin
                        overrunNext = 1'b1;
                    end
                end else if (audio_out_allowed) begin
                    stateNext = WAIT_TICK;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        if (!enable) begin
            stateNext    = IDLE;
            dividerNext  = '0;
            levelNext    = '0;
            activityNext = '0;
            sampleNext   = '0;
            overrunNext  = 1'b0;
            writeStrobe  = 1'b0;
        end
    end

    assign write_audio_out         = writeStrobe;
    assign left_channel_audio_out  = sampleReg;
    assign right_channel_audio_out = sampleReg;
    assign overrun                 = overrunReg;

endmodule

// File: tb/tb_tone_sample_writer.sv
// Scoreboard bench for tone_sample_writer: a behavioural model queues the
// samples that must reach the FIFO; a monitor checks every cycle's outputs.
module tb_tone_sample_writer;

    localparam int CF = 1000;
    localparam int SR = 100;
    localparam int DIV = CF / SR;
    localparam int SB = 12;
    localparam int HOLD = 8;
    localparam logic [SB-1:0] AMP = 12'h7E0;
    localparam logic [SB-1:0] STEP = 12'h065;
    localparam int AMPI = AMP;
    localparam int STEPI = STEP;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          sound = 1'b0;
    logic          allowed = 1'b0;
    logic          write;
    logic [SB-1:0] left;
    logic [SB-1:0] right;
    logic          overrun;

    int tests = 0;
    int fails = 0;

    tone_sample_writer #(
        .CLOCK_FREQUENCY(CF),
        .SAMPLE_RATE(SR),
        .SAMPLE_BITS(SB),
        .AMPLITUDE(AMP),
        .RAMP_STEP(STEP),
        .HOLD_SAMPLES(HOLD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .sound(sound),
        .audio_out_allowed(allowed),
        .write_audio_out(write),
        .left_channel_audio_out(left),
        .right_channel_audio_out(right),
        .overrun(overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: the block as seen from outside, in integers.
    int            mS1 = 0, mS2 = 0, mPrev = 0, mDiv = 0, mAct = 0, mLevel = 0;
    bit            mIdle = 1'b1, mPending = 1'b0, mOv = 1'b0;
    logic [SB-1:0] mData = '0;
    logic [SB-1:0] expQ[$];
    bit            mEdge, mTick, mWasActive;
    int            mSample;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mS1 = 0; mS2 = 0; mPrev = 0; mDiv = 0; mAct = 0; mLevel = 0;
            mIdle = 1'b1; mPending = 1'b0; mOv = 1'b0; mData = '0;
            expQ.delete();
        end else begin
            mEdge = (mS2 != mPrev);
            if (mIdle) begin
                if (enable) mIdle = 1'b0;
            end else if (!enable) begin
                if (mPending) void'(expQ.pop_back());
                mIdle = 1'b1; mPending = 1'b0; mOv = 1'b0;
                mDiv = 0; mAct = 0; mLevel = 0; mData = '0;
            end else begin
                mTick = (mDiv == DIV - 1);
                mDiv = mTick ? 0 : mDiv + 1;
                mWasActive = (mAct > 0);
                if (mEdge) mAct = HOLD;
                else if (mTick && mAct > 0) mAct = mAct - 1;
                if (mTick) begin
                    if (mWasActive) mLevel = (mLevel + STEPI > AMPI) ? AMPI : mLevel + STEPI;
                    else mLevel = (mLevel < STEPI) ? 0 : mLevel - STEPI;
                    mSample = (mS2 != 0) ? mLevel : -mLevel;
                    mData = mSample[SB-1:0];
                    if (mPending && !allowed) begin
                        mOv = 1'b1;
                        expQ[expQ.size()-1] = mData;
                    end else begin
                        expQ.push_back(mData);
                    end
                    mPending = 1'b1;
                end else if (mPending && allowed) begin
                    mPending = 1'b0;
                end
            end
            mPrev = mS2; mS2 = mS1; mS1 = int'(sound);
        end
    end

    // Monitor: independent of stimulus, pops the scoreboard on every strobe.
    logic [SB-1:0] got;
    always @(negedge clock) begin
        check("strobe", write, reset && mPending && allowed && enable);
        check("left", left, mData);
        check("right", right, mData);
        check("overrun", overrun, mOv);
        if (write) begin
            if (expQ.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_write actual=1 required=0 at %0t", $time);
            end else begin
                got = expQ.pop_front();
                check("written_sample", left, got);
                $display("[TB] write sample=%0h overrun=%0b t=%0t", left, overrun, $time);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // From the cycle enable was raised, count edges to the first strobe.
    task automatic firstStrobe(input string name);
        int n;
        n = 0;
        cyc(1);
        while (!write && n < 3 * DIV) begin
            cyc(1);
            n++;
        end
        check(name, n, DIV);
    endtask

    logic [SB-1:0] negAmp;
    int burst;

    initial begin
        negAmp = -AMP;
        // Reset with arbitrary inputs.
        for (int i = 0; i < 4; i++) begin
            enable = 1'($urandom); sound = 1'($urandom); allowed = 1'($urandom);
            cyc(1);
        end
        check("reset_left", left, 0);
        check("reset_write", write, 0);
        check("reset_overrun", overrun, 0);
        enable = 1'b0; sound = 1'b0; allowed = 1'b1;
        reset = 1'b1;
        cyc(20);

        // Silent tone: strobes every DIV cycles carrying zero.
        enable = 1'b1;
        firstStrobe("first_tick");
        cyc(5 * DIV);

        // Toggling tone: ramp to full scale, then hold the level.
        for (int i = 0; i < 9; i++) begin
            sound = ~sound;
            cyc(37);
        end
        cyc(25);
        check("saturated", left, sound ? AMP : negAmp);

        // Tone stops: hold then release down to zero.
        cyc(400);
        check("released", left, 0);

        // Overrun across two ticks, then a single strobe.
        for (int i = 0; i < 4; i++) begin
            sound = ~sound;
            cyc(29);
        end
        allowed = 1'b0;
        cyc(2 * DIV + 5);
        check("overrun_set", overrun, 1);
        allowed = 1'b1;
        cyc(3 * DIV);
        check("overrun_sticky", overrun, 1);

        // Drop enable while a write is pending.
        allowed = 1'b0;
        for (int i = 0; i < 3 * DIV && !mPending; i++) cyc(1);
        check("pending_seen", mPending, 1);
        enable = 1'b0;
        cyc(1);
        check("abandon_write", write, 0);
        check("abandon_left", left, 0);
        check("abandon_overrun", overrun, 0);
        cyc(5);
        allowed = 1'b1;
        enable = 1'b1;
        firstStrobe("reenable_tick");

        // Randomized traffic with bursts of back-pressure, enable drops and a reset.
        burst = 0;
        for (int i = 0; i < 6000; i++) begin
            if ((i / 1000) % 2 == 0) begin
                if ($urandom_range(29, 0) == 0) sound = ~sound;
            end else if ($urandom_range(499, 0) == 0) begin
                sound = ~sound;
            end
            if (burst > 0) begin
                burst--;
                allowed = 1'b0;
            end else begin
                allowed = ($urandom_range(3, 0) != 0);
                if ($urandom_range(99, 0) == 0) burst = $urandom_range(30, 5);
            end
            if ($urandom_range(1499, 0) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(3, 0) == 0) enable = 1'b1;
            if (i == 3000) reset = 1'b0;
            if (i == 3003) reset = 1'b1;
            cyc(1);
        end

        enable = 1'b0;
        cyc(2);
        check("queue_drained", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
